// File: rtl/micro_sequencer.sv
// Microsequencer for the AGEX datapath: latches one decoded instruction per handshake and
// steps the microstate code. Optional MEM_TIMEOUT_EN aborts memory waits after TIMEOUT_CYCLES.
module micro_sequencer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inst_valid,
   output logic       inst_ready,
   input  logic [7:0] opcode,
   input  logic [7:0] modrm,
   output logic [7:0] opcode_q,
   output logic [7:0] modrm_q,
   output logic [7:0] state,
   output logic       mem_req,
   output logic       mem_we,
   input  logic       mem_rdy,
   output logic       instr_done,
   output logic       illegal_op,
   output logic       mem_timeout
);

   localparam logic [7:0] S_IDLE    = 8'd0;
   localparam logic [7:0] S_AGEN    = 8'd1;
   localparam logic [7:0] S_RD_WAIT = 8'd2;
   localparam logic [7:0] S_LD_ALU  = 8'd3;
   localparam logic [7:0] S_WB_REG  = 8'd4;
   localparam logic [7:0] S_ALU_MDR = 8'd5;
   localparam logic [7:0] S_WR_WAIT = 8'd6;
   localparam logic [7:0] S_REG_ALU = 8'd8;
   localparam logic [7:0] S_MOV_IMM = 8'd12;
   localparam logic [7:0] S_JMP     = 8'd16;

   logic [7:0] state_q, state_d;
   logic [7:0] opcode_d, modrm_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;
   logic       accept;
   logic       is_mov, is_alu, is_jmp, is_loadop_in, is_loadop_q, wait_abort;

   assign accept = (state_q == S_IDLE) && inst_valid;

   always_comb begin
      is_mov       = (opcode[7:3] == 5'b10111);
      is_jmp       = (opcode == 8'hE9) || (opcode == 8'hEB);
      is_loadop_in = (opcode == 8'h03) || (opcode == 8'h0B);
      is_alu       = 1'b0;
      case (opcode)
         8'h01, 8'h03, 8'h09, 8'h0B, 8'h81, 8'h83, 8'hC1, 8'hD1, 8'hD3: is_alu = 1'b1;
         default: is_alu = 1'b0;
      endcase
   end

   // Load-op and read-modify-write share the read half; the latched opcode picks the tail.
   assign is_loadop_q = (opcode_q == 8'h03) || (opcode_q == 8'h0B);

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_wait;

   assign in_wait    = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
   // cnt_q counts completed wait cycles, so the current cycle is number cnt_q+1.
   assign wait_abort = in_wait && !mem_rdy && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (in_wait && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   assign wait_abort = 1'b0;
`endif

   always_comb begin
      state_d   = S_IDLE;
      opcode_d  = opcode_q;
      modrm_d   = modrm_q;
      illegal_d = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (inst_valid) begin
               opcode_d = opcode;
               modrm_d  = modrm;
               if (is_mov)                    state_d = S_MOV_IMM;
               else if (is_jmp)               state_d = S_JMP;
               else if (is_alu && modrm[7:6] == 2'b11) state_d = S_REG_ALU;
               else if (is_alu)               state_d = S_AGEN;
               else                           illegal_d = 1'b1;
            end
         end
         S_AGEN: state_d = S_RD_WAIT;
         S_RD_WAIT: begin
            if (mem_rdy)         state_d = S_LD_ALU;
            else if (wait_abort) timeout_d = 1'b1;
            else                 state_d = S_RD_WAIT;
         end
         S_LD_ALU:  state_d = is_loadop_q ? S_WB_REG : S_ALU_MDR;
         S_ALU_MDR: state_d = S_WR_WAIT;
         S_WR_WAIT: begin
            if (mem_rdy)         state_d = S_IDLE;
            else if (wait_abort) timeout_d = 1'b1;
            else                 state_d = S_WR_WAIT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         opcode_q  <= 8'h00;
         modrm_q   <= 8'h00;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         modrm_q   <= modrm_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   assign state       = state_q;
   assign inst_ready  = (state_q == S_IDLE) && !rst;
   assign mem_req     = (state_q == S_RD_WAIT) || (state_q == S_WR_WAIT);
   assign mem_we      = (state_q == S_WR_WAIT);
   // Gated by rst so an abandoned instruction never reports completion.
   assign instr_done  = !rst && ((state_q == S_WB_REG) || (state_q == S_REG_ALU) ||
                                 (state_q == S_MOV_IMM) || (state_q == S_JMP) ||
                                 ((state_q == S_WR_WAIT) && mem_rdy));
   assign illegal_op  = illegal_q;
   assign mem_timeout = timeout_q;

   logic unused_ok;
   assign unused_ok = accept;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer; the timeout scenario runs only
// when MEM_TIMEOUT_EN is defined.
module tb_micro_sequencer;

   logic       clk = 1'b0;
   logic       rst, inst_valid, inst_ready, mem_rdy;
   logic [7:0] opcode, modrm, opcode_q, modrm_q, state;
   logic       mem_req, mem_we, instr_done, illegal_op, mem_timeout;
   int         total = 0;
   int         bad   = 0;

   micro_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .opcode(opcode), .modrm(modrm), .opcode_q(opcode_q), .modrm_q(modrm_q),
      .state(state), .mem_req(mem_req), .mem_we(mem_we), .mem_rdy(mem_rdy),
      .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are changed afterwards, outputs sampled #1 later.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [7:0] op, input logic [7:0] mr);
      inst_valid = 1'b1; opcode = op; modrm = mr;
      cyc();
      inst_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; inst_valid = 1'b1; opcode = 8'hB8; modrm = 8'h11; mem_rdy = 1'b0;
      cyc(); cyc();
      #1;
      total++; if (state !== 8'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
      total++; if (opcode_q !== 8'h00) begin bad++; $display("FAIL reset_opcode_q got=%h exp=00", opcode_q); end
      total++; if (inst_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", inst_ready); end
      total++; if ({mem_req, mem_we, instr_done, illegal_op, mem_timeout} !== 5'b0) begin
         bad++; $display("FAIL reset_outs got=%b exp=00000", {mem_req, mem_we, instr_done, illegal_op, mem_timeout});
      end
      rst = 1'b0; inst_valid = 1'b0;
      #1;
      total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", inst_ready); end
   endtask

   task automatic test_mov();
      accept(8'hB8, 8'h00);
      #1;
      total++; if (state !== 8'd12) begin bad++; $display("FAIL mov_state got=%0d exp=12", state); end
      total++; if (instr_done !== 1'b1) begin bad++; $display("FAIL mov_done got=%b exp=1", instr_done); end
      total++; if (opcode_q !== 8'hB8) begin bad++; $display("FAIL mov_opcode_q got=%h exp=b8", opcode_q); end
      total++; if (inst_ready !== 1'b0) begin bad++; $display("FAIL mov_ready got=%b exp=0", inst_ready); end
      cyc(); #1;
      total++; if (state !== 8'd0 || instr_done !== 1'b0) begin
         bad++; $display("FAIL mov_end got=%0d/%b exp=0/0", state, instr_done);
      end
   endtask

   task automatic test_load_op();
      int   st[7]  = '{1, 2, 2, 2, 3, 4, 0};
      logic rdy[7] = '{0, 0, 0, 1, 0, 0, 0};
      logic req[7] = '{0, 1, 1, 1, 0, 0, 0};
      logic dn[7]  = '{0, 0, 0, 0, 0, 1, 0};
      accept(8'h03, 8'h9D);
      total++; if (modrm_q !== 8'h9D) begin bad++; $display("FAIL ldop_modrm_q got=%h exp=9d", modrm_q); end
      for (int i = 0; i < 7; i++) begin
         mem_rdy = rdy[i];
         #1;
         total++; if (state !== 8'(st[i])) begin bad++; $display("FAIL ldop_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
         total++; if (mem_req !== req[i]) begin bad++; $display("FAIL ldop_req[%0d] got=%b exp=%b", i, mem_req, req[i]); end
         total++; if (instr_done !== dn[i]) begin bad++; $display("FAIL ldop_done[%0d] got=%b exp=%b", i, instr_done, dn[i]); end
         cyc();
      end
      mem_rdy = 1'b0;
   endtask

   task automatic test_rmw();
      int   st[6]  = '{1, 2, 3, 5, 6, 0};
      logic req[6] = '{0, 1, 0, 0, 1, 0};
      logic we[6]  = '{0, 0, 0, 0, 1, 0};
      logic dn[6]  = '{0, 0, 0, 0, 1, 0};
      mem_rdy = 1'b1;
      accept(8'h01, 8'h9D);
      for (int i = 0; i < 6; i++) begin
         #1;
         total++; if (state !== 8'(st[i])) begin bad++; $display("FAIL rmw_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
         total++; if (mem_req !== req[i]) begin bad++; $display("FAIL rmw_req[%0d] got=%b exp=%b", i, mem_req, req[i]); end
         total++; if (mem_we !== we[i]) begin bad++; $display("FAIL rmw_we[%0d] got=%b exp=%b", i, mem_we, we[i]); end
         total++; if (instr_done !== dn[i]) begin bad++; $display("FAIL rmw_done[%0d] got=%b exp=%b", i, instr_done, dn[i]); end
         cyc();
      end
      mem_rdy = 1'b0;
   endtask

   task automatic test_back_to_back();
      accept(8'h83, 8'hC0);
      inst_valid = 1'b1; opcode = 8'hE9; modrm = 8'h00;
      #1;
      total++; if (state !== 8'd8 || inst_ready !== 1'b0) begin
         bad++; $display("FAIL b2b_alu got=%0d/%b exp=8/0", state, inst_ready);
      end
      cyc(); #1;
      total++; if (state !== 8'd0 || inst_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_idle got=%0d/%b exp=0/1", state, inst_ready);
      end
      total++; if (opcode_q !== 8'h83) begin bad++; $display("FAIL b2b_ignored got=%h exp=83", opcode_q); end
      cyc(); inst_valid = 1'b0; #1;
      total++; if (state !== 8'd16 || inst_ready !== 1'b0 || instr_done !== 1'b1) begin
         bad++; $display("FAIL b2b_jmp got=%0d/%b/%b exp=16/0/1", state, inst_ready, instr_done);
      end
      total++; if (opcode_q !== 8'hE9) begin bad++; $display("FAIL b2b_opcode_q got=%h exp=e9", opcode_q); end
      cyc(); #1;
      total++; if (state !== 8'd0) begin bad++; $display("FAIL b2b_end got=%0d exp=0", state); end
   endtask

   task automatic test_illegal();
      accept(8'h0F, 8'hC0);
      #1;
      total++; if (state !== 8'd0 || illegal_op !== 1'b1 || instr_done !== 1'b0) begin
         bad++; $display("FAIL illegal_pulse got=%0d/%b/%b exp=0/1/0", state, illegal_op, instr_done);
      end
      cyc(); #1;
      total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL illegal_once got=%b exp=0", illegal_op); end
   endtask

   task automatic test_reset_mid();
      mem_rdy = 1'b0;
      accept(8'h03, 8'h9D);
      cyc(); #1;
      total++; if (state !== 8'd2 || mem_req !== 1'b1) begin
         bad++; $display("FAIL midrst_wait got=%0d/%b exp=2/1", state, mem_req);
      end
      rst = 1'b1;
      cyc(); #1;
      total++; if (state !== 8'd0 || mem_req !== 1'b0 || instr_done !== 1'b0) begin
         bad++; $display("FAIL midrst_state got=%0d/%b/%b exp=0/0/0", state, mem_req, instr_done);
      end
      total++; if (opcode_q !== 8'h00) begin bad++; $display("FAIL midrst_opcode_q got=%h exp=00", opcode_q); end
      rst = 1'b0;
      cyc();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int   st[7] = '{1, 2, 2, 2, 2, 0, 0};
      logic to[7] = '{0, 0, 0, 0, 0, 1, 0};
      mem_rdy = 1'b0;
      accept(8'h03, 8'h9D);
      for (int i = 0; i < 7; i++) begin
         #1;
         total++; if (state !== 8'(st[i])) begin bad++; $display("FAIL to_state[%0d] got=%0d exp=%0d", i, state, st[i]); end
         total++; if (mem_timeout !== to[i]) begin bad++; $display("FAIL to_pulse[%0d] got=%b exp=%b", i, mem_timeout, to[i]); end
         total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL to_done[%0d] got=%b exp=0", i, instr_done); end
         cyc();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_mov();
      test_load_op();
      test_rmw();
      test_back_to_back();
      test_illegal();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Microsequencer for the x86-subset AGEX datapath. Accepts one decoded instruction (opcode + ModR/M) per handshake, latches it, and steps the 8-bit `state` code consumed by `datapathCS` through the required microstates. It drives the memory request/write strobes around MAR/MDR, waits on memory ready, and signals instruction completion. It sits between fetch/decode and the datapath control decoder.

## Interface
- `TIMEOUT_CYCLES`, default 64: memory-wait cycles before abort; used only with `MEM_TIMEOUT_EN`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `inst_valid` input 1: instruction presented.
- `inst_ready` output 1: sequencer can accept; equals `(state==0) && !rst`.
- `opcode` input 8: primary opcode; sampled on accept.
- `modrm` input 8: ModR/M byte; sampled on accept.
- `opcode_q` output 8: latched opcode, feeds `datapathCS`.
- `modrm_q` output 8: latched ModR/M, feeds `datapathCS`.
- `state` output 8: current microstate code, feeds `datapathCS`.
- `mem_req` output 1: memory access active.
- `mem_we` output 1: memory access is a write.
- `mem_rdy` input 1: memory completed the current access.
- `instr_done` output 1: final microstate of a legal instruction.
- `illegal_op` output 1: one-cycle pulse for an unsupported opcode.
- `mem_timeout` output 1: one-cycle pulse when a memory wait is aborted.

## Operation
- State codes: IDLE=0, AGEN=1 (AGEN→MAR), RD_WAIT=2, LD_ALU=3 (MDR→ALU_R), WB_REG=4 (ALU→REG), ALU_MDR=5 (ALU→MDR), WR_WAIT=6, REG_ALU=8, MOV_IMM=12, JMP=16. No other values are ever driven.
- Accept: in IDLE, `inst_valid` high at an edge latches `opcode_q`/`modrm_q`, and `state` moves to the first state of the flow. `inst_valid` is ignored outside IDLE.
- `mod = modrm[7:6]`. Flows:
  - B8–BF: 12 → 0.
  - 01, 03, 09, 0B, 81, 83, C1, D1, D3 with mod==11: 8 → 0.
  - 03, 0B with mod!=11 (load-op): 1 → 2 → 3 → 4 → 0.
  - 01, 09, 81, 83, C1, D1, D3 with mod!=11 (read-modify-write): 1 → 2 → 3 → 5 → 6 → 0.
  - E9, EB: 16 → 0.
  - Any other opcode: next state is 0. `illegal_op` pulses for the cycle after the accept edge. `instr_done` stays low.
- RD_WAIT and WR_WAIT hold until `mem_rdy` is sampled high, then advance. `mem_rdy` is ignored in all other states.
- Outputs decoded from registered `state`:
  - `mem_req` = state∈{2,6}.
  - `mem_we` = (state==6).
  - `instr_done` = state∈{4,8,12,16}, or (state==6 && `mem_rdy`).
- Reset: the next edge forces `state`=0, `opcode_q`=0, `modrm_q`=0, and clears the timeout counter. Reset values: `state`=0, `mem_req`=0, `mem_we`=0, `instr_done`=0, `illegal_op`=0, `mem_timeout`=0, `inst_ready`=0 while `rst` is high. Reset mid-instruction abandons the instruction; no `instr_done` is produced.

## Timing
- Accept edge k: first microstate is visible in cycle k+1.
- Minimum cycles from accept to return to IDLE:
  - MOV, reg-reg ALU, and JMP: 1.
  - Load-op: 4.
  - Read-modify-write: 5.
  - Each extra wait cycle adds 1.
- `mem_rdy` high in the first cycle of RD_WAIT advances the state at the next edge; there is no minimum dwell.
- Back-to-back instructions: a new accept is possible in the IDLE cycle directly after completion, giving 1 idle cycle between instructions.
- `rst` and `inst_valid` high at the same edge: reset wins, and nothing is latched.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A counter, wide enough for `TIMEOUT_CYCLES`, counts cycles spent in state 2 or 6 and resets on entry to either state.
  - If the count reaches `TIMEOUT_CYCLES` with `mem_rdy` low, the next state is 0 and `mem_timeout` pulses for one cycle. `instr_done` is not asserted.
  - `mem_rdy` in the same cycle as the limit takes priority; the access completes normally.
- `MEM_TIMEOUT_EN` undefined: waits are unbounded, `mem_timeout` is tied 0, and no counter is built.

## Test plan
- Reset, then opcode B8 accepted → `state` 12 for one cycle with `instr_done`=1, then 0. `opcode_q`=B8.
- Opcode 03, modrm 9D, `mem_rdy` delayed 3 cycles → `state` sequence 1, 2, 2, 2, 3, 4, 0. `mem_req`=1 for exactly 3 cycles. `instr_done` high only in state 4.
- Opcode 01, modrm 9D, `mem_rdy` held 1 → 1, 2, 3, 5, 6, 0. `mem_we`=1 only in state 6. `instr_done` high in state 6.
- Opcode 83/modrm C0 followed immediately by E9 → 8, 0, 16, 0. `inst_ready` high only in the IDLE cycles.
- Opcode 0F → `illegal_op` pulses once, `state` stays 0, `instr_done`=0. Separately, `rst` asserted during state 2 → `state`=0 and `mem_req`=0 after the reset edge.
- With `MEM_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, opcode 03/9D with `mem_rdy` held low → four RD_WAIT cycles, then `state`=0 with one `mem_timeout` pulse and no `instr_done`.
